// File: rtl/lhn_serial_subtractor.sv
// lhn_serial_subtractor
// Bit-serial subtractor computing d = x - y - borrowin, one bit per clock,
// LSB first. A three-state FSM (IDLE, RUN, DONE) captures the operands,
// walks the bit counter across WIDTH cycles, then presents the result with
// a single-cycle done pulse. Difference, borrow-out and overflow hold their
// values until the next accepted start.
module lhn_serial_subtractor #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrowin,
  output logic [WIDTH-1:0] d,
  output logic             borrowout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  // Counter wide enough to index bits 0..WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             borrow_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrowout_q;
  logic             overflow_q;
  logic             busy_q;
  logic             done_q;

  // Full-subtractor slice for the bit currently addressed by the counter.
  logic x_bit;
  logic y_bit;
  logic diff_bit;
  logic borrow_d;

  // Combinational single-bit subtractor on the captured operands.
  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    x_bit    = x_q[cnt_q];
    y_bit    = y_q[cnt_q];
    diff_bit = x_bit ^ y_bit ^ borrow_q;
    borrow_d = (~x_bit & y_bit) | (~x_bit & borrow_q) | (y_bit & borrow_q);
  end

  // FSM, datapath registers and registered status outputs in one process.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      // NOTE: operand and result registers are plain flops here, so clearing them in reset is cheap and keeps outputs defined.
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      borrow_q    <= 1'b0;
      diff_q      <= '0;
      borrowout_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q         <= x;
            y_q         <= y;
            borrow_q    <= borrowin;
            cnt_q       <= '0;
            diff_q      <= '0;
            borrowout_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end
        end

        RUN: begin
          // start is deliberately not looked at here: a request while busy is dropped.
          diff_q[cnt_q] <= diff_bit;
          borrow_q      <= borrow_d;
          if (cnt_q == LAST_BIT) begin
            // Last bit: the borrow leaving the MSB is the final borrow, and the
            // MSB just produced decides signed overflow.
            borrowout_q <= borrow_d;
            overflow_q  <= (x_q[WIDTH-1] != y_q[WIDTH-1]) &&
                           (diff_bit != x_q[WIDTH-1]);
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DONE: begin
          // Result cycle; a start seen here is ignored.
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign d         = diff_q;
  assign borrowout = borrowout_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lhn_serial_subtractor.sv
// Testbench for lhn_serial_subtractor: directed corner vectors plus random
// operands, each checked against an arithmetic reference model.
module tb_lhn_serial_subtractor;

  localparam int W = 7;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         borrowin;
  logic [W-1:0] d;
  logic         borrowout;
  logic         overflow;
  logic         busy;
  logic         done;

  int n_checks;
  int n_pass;

  lhn_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x         (x),
    .y         (y),
    .borrowin  (borrowin),
    .d         (d),
    .borrowout (borrowout),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  task automatic model(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic ba,
                       output logic [W-1:0] exp_d, output logic exp_bo, output logic exp_ov);
    int full;
    int sx;
    int sy;
    int sdiff;
    full   = int'(xa) - int'(ya) - int'(ba);
    exp_d  = W'(full);
    exp_bo = (full < 0);
    sx     = xa[W-1] ? int'(xa) - (1 << W) : int'(xa);
    sy     = ya[W-1] ? int'(ya) - (1 << W) : int'(ya);
    sdiff  = sx - sy - int'(ba);
    exp_ov = (sdiff < -(1 << (W - 1))) || (sdiff > (1 << (W - 1)) - 1);
  endtask

  // One subtraction. Inputs are scrambled after acceptance; with mid=1 a
  // second start with other operands is pulsed in the third RUN cycle.
  task automatic do_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] ya,
                       input logic ba, input bit mid);
    logic [W-1:0] exp_d;
    logic         exp_bo;
    logic         exp_ov;
    int           done_at;
    int           extra_done;
    bit           busy_ok;
    model(xa, ya, ba, exp_d, exp_bo, exp_ov);
    @(negedge clk);
    x = xa; y = ya; borrowin = ba; start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    done_at = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 4 * W && done_at == 0; k++) begin
      if (k > 1) @(negedge clk);
      x        = W'($urandom);
      y        = W'($urandom);
      borrowin = 1'($urandom);
      start    = (mid && k == 3) ? 1'b1 : 1'b0;
      if (done) done_at = k;
      else if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, " latency"}, done_at, W + 1);
    check({tag, " busy_run"}, busy_ok, 1);
    check({tag, " busy_done"}, busy, 0);
    check({tag, " d"}, d, exp_d);
    check({tag, " borrowout"}, borrowout, exp_bo);
    check({tag, " overflow"}, overflow, exp_ov);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
    check({tag, " d_hold"}, d, exp_d);
    if (mid) begin
      extra_done = 0;
      for (int k = 0; k < W + 3; k++) begin
        @(negedge clk);
        if (done || busy) extra_done++;
      end
      check({tag, " no_second_op"}, extra_done, 0);
      check({tag, " d_hold_late"}, d, exp_d);
    end
  endtask

  initial begin
    int done_t[3];
    int nd;
    int cnt;
    logic [W-1:0] ed;
    logic eb;
    logic eo;

    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1; start = 1'b0; x = '0; y = '0; borrowin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset d", d, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset bo_ov", {borrowout, overflow}, 0);
    reset = 1'b0;

    // Directed vectors.
    do_op("5-3",        7'd5,   7'd3,   1'b0, 1'b0);
    do_op("3-5",        7'd3,   7'd5,   1'b0, 1'b0);
    do_op("min-1",      7'h40,  7'd1,   1'b0, 1'b0);
    do_op("3F-7F",      7'h3F,  7'h7F,  1'b0, 1'b0);
    do_op("0-0-1",      7'd0,   7'd0,   1'b1, 1'b0);
    do_op("min-0-1",    7'h40,  7'd0,   1'b1, 1'b0);
    do_op("7F-7F-1",    7'h7F,  7'h7F,  1'b1, 1'b0);
    do_op("mid_start",  7'd100, 7'd37,  1'b0, 1'b1);

    // Reset in the fourth RUN cycle aborts with no done pulse.
    @(negedge clk);
    x = 7'd50; y = 7'd20; borrowin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort d", d, 0);
    check("abort done", done, 0);
    check("abort bo_ov", {borrowout, overflow}, 0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort no_done", cnt, 0);
    do_op("after_abort", 7'd10, 7'd4, 1'b0, 1'b0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; x = 7'd9; y = 7'd2;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_prio busy", busy, 0);
    @(negedge clk);
    check("rst_prio busy2", busy, 0);

    // Back-to-back: start held high yields a result every W+2 cycles.
    model(7'd77, 7'd13, 1'b1, ed, eb, eo);
    @(negedge clk);
    x = 7'd77; y = 7'd13; borrowin = 1'b1; start = 1'b1;
    nd = 0;
    for (int k = 0; k < 4 * (W + 2) && nd < 3; k++) begin
      @(negedge clk);
      if (done) begin
        done_t[nd] = k;
        nd++;
      end
    end
    start = 1'b0;
    check("b2b count", nd, 3);
    if (nd == 3) begin
      check("b2b gap1", done_t[1] - done_t[0], W + 2);
      check("b2b gap2", done_t[2] - done_t[1], W + 2);
    end
    check("b2b d", d, ed);
    repeat (2 * (W + 2)) @(negedge clk);

    // Random operands, some with an ignored mid-run start.
    for (int i = 0; i < 25; i++)
      do_op("rand", W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
